// File: rtl/countdown_timer_param.sv
// countdown_timer_param
//   Prescaled countdown timer for game/round timing. A prescaler divides clk
//   into count steps. On each step the count goes down by one. When it
//   expires, the timer either stops in DONE (one-shot) or reloads and keeps
//   running (AUTO_RELOAD). It supports pause/resume, abort (stop) and
//   restart (start).
//
// Ports
//   clk      : system clock; all state changes on its rising edge
//   reset    : synchronous, active-high reset
//   start    : start or restart the countdown from the reload value
//   stop     : abort the countdown and return to IDLE
//   pause    : level; while high, RUN freezes (prescaler and count hold)
//   load_en  : write load_val into the reload register (IDLE/DONE only)
//   load_val : new reload value
//   count    : current remaining count (registered)
//   running  : high in RUN only
//   paused   : high in PAUSED only
//   done     : high in DONE (one-shot expiry)
//   expired  : one-cycle pulse when the count expires
//   step     : one-cycle pulse on every count decrement/reload
module countdown_timer_param #(
   parameter int unsigned WIDTH        = 5,
   parameter int unsigned PRESCALE     = 100000000,
   parameter int unsigned DEFAULT_LOAD = 30,
   parameter int unsigned AUTO_RELOAD  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             paused,
   output logic             done,
   output logic             expired,
   output logic             step
);

   localparam int unsigned      PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] LOAD_INIT  = WIDTH'(DEFAULT_LOAD);
   localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] reload_reg, reload_nxt;
   logic [WIDTH-1:0] count_r, count_nxt;
   logic [PW-1:0]    presc, presc_nxt;
   logic             exp_r, exp_nxt;
   logic             step_r, step_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         reload_reg <= LOAD_INIT;
         count_r    <= LOAD_INIT;
         presc      <= '0;
         exp_r      <= 1'b0;
         step_r     <= 1'b0;
      end else begin
         state      <= state_nxt;
         reload_reg <= reload_nxt;
         count_r    <= count_nxt;
         presc      <= presc_nxt;
         exp_r      <= exp_nxt;
         step_r     <= step_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      reload_nxt = reload_reg;
      count_nxt  = count_r;
      presc_nxt  = presc;
      exp_nxt    = 1'b0;
      step_nxt   = 1'b0;

      if (stop) begin
         state_nxt = S_IDLE;
         count_nxt = reload_reg;
         presc_nxt = '0;
      end else if (start) begin
         presc_nxt = '0;
         // A zero-length one-shot round expires immediately.
         if ((reload_reg == '0) && (AUTO_RELOAD == 0)) begin
            state_nxt = S_DONE;
            count_nxt = '0;
            exp_nxt   = 1'b1;
         end else begin
            state_nxt = S_RUN;
            count_nxt = reload_reg;
         end
      end else if (load_en && ((state == S_IDLE) || (state == S_DONE))) begin
         // Mid-round loads are ignored so the round length stays stable.
         state_nxt  = S_IDLE;
         reload_nxt = load_val;
         count_nxt  = load_val;
      end else if ((state == S_RUN) && pause) begin
         state_nxt = S_PAUSED;
      end else if ((state == S_RUN) || ((state == S_PAUSED) && !pause)) begin
         // The resume edge counts like a RUN cycle, so pausing neither
         // loses nor gains prescaler time.
         state_nxt = S_RUN;
         if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            step_nxt  = 1'b1;
            if (count_r > ONE) begin
               count_nxt = count_r - ONE;
            end else begin
               // count of 0 here only occurs for an auto-reload of zero
               exp_nxt = 1'b1;
               if (AUTO_RELOAD != 0) begin
                  count_nxt = reload_reg;
               end else begin
                  count_nxt = '0;
                  state_nxt = S_DONE;
               end
            end
         end else begin
            presc_nxt = presc + 1'b1;
         end
      end
   end

   assign count   = count_r;
   assign running = (state == S_RUN);
   assign paused  = (state == S_PAUSED);
   assign done    = (state == S_DONE);
   assign expired = exp_r;
   assign step    = step_r;

endmodule

// File: tb/tb_countdown_timer_param.sv
module tb_countdown_timer_param;

   logic       clk = 1'b0;
   logic       reset, start, stop, pause, load_en;
   logic [4:0] load_val;

   logic [4:0] count_a, count_b, count_c;
   logic running_a, paused_a, done_a, expired_a, step_a;
   logic running_b, paused_b, done_b, expired_b, step_b;
   logic running_c, paused_c, done_c, expired_c, step_c;

   always #5 clk = ~clk;

   // a: one-shot, PRESCALE 4, load 3
   countdown_timer_param #(.WIDTH(5), .PRESCALE(4), .DEFAULT_LOAD(3), .AUTO_RELOAD(0)) dut_a (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .load_en(load_en), .load_val(load_val), .count(count_a), .running(running_a),
      .paused(paused_a), .done(done_a), .expired(expired_a), .step(step_a));

   // b: auto-reload, PRESCALE 4, load 2
   countdown_timer_param #(.WIDTH(5), .PRESCALE(4), .DEFAULT_LOAD(2), .AUTO_RELOAD(1)) dut_b (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .load_en(load_en), .load_val(load_val), .count(count_b), .running(running_b),
      .paused(paused_b), .done(done_b), .expired(expired_b), .step(step_b));

   // c: one-shot, PRESCALE 1, load 3
   countdown_timer_param #(.WIDTH(5), .PRESCALE(1), .DEFAULT_LOAD(3), .AUTO_RELOAD(0)) dut_c (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .load_en(load_en), .load_val(load_val), .count(count_c), .running(running_c),
      .paused(paused_c), .done(done_c), .expired(expired_c), .step(step_c));

   int total = 0;
   int bad   = 0;

   // Reference model: mode plus "cycles elapsed toward the next step".
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
   int cfg_p  [3] = '{4, 4, 1};
   int cfg_dl [3] = '{3, 2, 3};
   int cfg_ar [3] = '{0, 1, 0};
   int m_mode [3];
   int m_rel  [3];
   int m_cnt  [3];
   int m_tick [3];
   int m_exp  [3];
   int m_step [3];

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         m_exp[k]  = 0;
         m_step[k] = 0;
         if (reset) begin
            m_mode[k] = M_IDLE; m_rel[k] = cfg_dl[k]; m_cnt[k] = cfg_dl[k]; m_tick[k] = 0;
         end else if (stop) begin
            m_mode[k] = M_IDLE; m_cnt[k] = m_rel[k]; m_tick[k] = 0;
         end else if (start) begin
            m_tick[k] = 0;
            if (m_rel[k] == 0 && cfg_ar[k] == 0) begin
               m_mode[k] = M_DONE; m_cnt[k] = 0; m_exp[k] = 1;
            end else begin
               m_mode[k] = M_RUN; m_cnt[k] = m_rel[k];
            end
         end else if (load_en && (m_mode[k] == M_IDLE || m_mode[k] == M_DONE)) begin
            m_mode[k] = M_IDLE; m_rel[k] = int'(load_val); m_cnt[k] = int'(load_val);
         end else if (m_mode[k] == M_RUN && pause) begin
            m_mode[k] = M_PAUSED;
         end else if (m_mode[k] == M_RUN || (m_mode[k] == M_PAUSED && !pause)) begin
            m_mode[k] = M_RUN;
            m_tick[k] = m_tick[k] + 1;
            if (m_tick[k] == cfg_p[k]) begin
               m_tick[k] = 0;
               m_step[k] = 1;
               if (m_cnt[k] >= 2) m_cnt[k] = m_cnt[k] - 1;
               else begin
                  m_exp[k] = 1;
                  if (cfg_ar[k] != 0) m_cnt[k] = m_rel[k];
                  else begin m_cnt[k] = 0; m_mode[k] = M_DONE; end
               end
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [4:0] ac, af, ef;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin ac = count_a; af = {running_a, paused_a, done_a, expired_a, step_a}; end
            1:       begin ac = count_b; af = {running_b, paused_b, done_b, expired_b, step_b}; end
            default: begin ac = count_c; af = {running_c, paused_c, done_c, expired_c, step_c}; end
         endcase
         ef = {m_mode[k] == M_RUN, m_mode[k] == M_PAUSED, m_mode[k] == M_DONE,
               m_exp[k] != 0, m_step[k] != 0};
         total++;
         assert (ac === 5'(m_cnt[k])) else begin
            bad++;
            $error("FAIL %s dut%0d count got=%0d want=%0d", tag, k, ac, m_cnt[k]);
         end
         total++;
         assert (af === ef) else begin
            bad++;
            $error("FAIL %s dut%0d flags{run,pau,done,exp,step} got=%b want=%b", tag, k, af, ef);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(tag);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; load_en = 1'b0; load_val = '0;
      run(2, "reset");
      reset = 1'b0;
      chk("reset_count_a", 32'(count_a), 3);
      chk("reset_count_b", 32'(count_b), 2);
      chk("reset_flags_a", 32'({running_a, paused_a, done_a, expired_a, step_a}), 0);

      // one-shot countdown; start edge is edge 0
      start = 1'b1; cyc("t1_start"); start = 1'b0;
      run(11, "t1_run");
      cyc("t1_e12");
      chk("t1_expired_e12", 32'(expired_a), 1);
      chk("t1_done_e12", 32'(done_a), 1);
      chk("t1_count_e12", 32'(count_a), 0);
      run(20, "t1_hold");

      // pause for edges 6..15
      stop = 1'b1; cyc("t2_stop"); stop = 1'b0;
      start = 1'b1; cyc("t2_start"); start = 1'b0;
      run(5, "t2_run");
      pause = 1'b1; run(10, "t2_pause");
      chk("t2_paused", 32'(paused_a), 1);
      chk("t2_frozen", 32'(count_a), 2);
      pause = 1'b0; run(2, "t2_resume");
      cyc("t2_e18");
      chk("t2_step_e18", 32'(step_a), 1);
      chk("t2_count_e18", 32'(count_a), 1);
      run(3, "t2_run2");
      cyc("t2_e22");
      chk("t2_expired_e22", 32'(expired_a), 1);

      // auto-reload
      stop = 1'b1; cyc("t3_stop"); stop = 1'b0;
      start = 1'b1; cyc("t3_start"); start = 1'b0;
      run(7, "t3_run");
      cyc("t3_e8");
      chk("t3_expired_b_e8", 32'(expired_b), 1);
      chk("t3_reload_b_e8", 32'(count_b), 2);
      run(17, "t3_run2");
      stop = 1'b1; cyc("t3_e26"); stop = 1'b0;
      chk("t3_stop_running_b", 32'(running_b), 0);
      chk("t3_stop_count_b", 32'(count_b), 2);

      // load / priority
      load_en = 1'b1; load_val = 5'd7; cyc("t4_load7"); load_en = 1'b0;
      chk("t4_load_idle", 32'(count_a), 7);
      start = 1'b1; cyc("t4_start"); start = 1'b0;
      run(2, "t4_run");
      load_en = 1'b1; load_val = 5'd20; cyc("t4_load_run"); load_en = 1'b0;
      run(40, "t4_to_done");
      chk("t4_done_a", 32'(done_a), 1);
      start = 1'b1; load_en = 1'b1; load_val = 5'd9; cyc("t4_start_load"); start = 1'b0; load_en = 1'b0;
      chk("t4_start_wins", 32'(count_a), 7);
      run(6, "t4_p1_run");
      cyc("t4_p1_e7");
      chk("t4_p1_expired_c", 32'(expired_c), 1);

      // reset mid-run at count 1, prescaler 2
      run(18, "t5_run");
      cyc("t5_e26");
      chk("t5_pre_count", 32'(count_a), 1);
      reset = 1'b1; cyc("t5_reset"); reset = 1'b0;
      chk("t5_reset_count", 32'(count_a), 3);
      chk("t5_reset_expired", 32'(expired_a), 0);
      start = 1'b1; cyc("t5_start"); start = 1'b0;
      run(2, "t5_run2");
      start = 1'b1; cyc("t5_restart"); start = 1'b0;
      chk("t5_restart_count", 32'(count_a), 3);
      run(3, "t5_run3");
      cyc("t5_step");
      chk("t5_step_after_restart", 32'(step_a), 1);

      // zero load and PRESCALE=1
      stop = 1'b1; cyc("t6_stop"); stop = 1'b0;
      load_en = 1'b1; load_val = 5'd0; cyc("t6_load0"); load_en = 1'b0;
      start = 1'b1; cyc("t6_start0"); start = 1'b0;
      chk("t6_zero_expired", 32'(expired_a), 1);
      chk("t6_zero_done", 32'(done_a), 1);
      cyc("t6_after");
      chk("t6_zero_pulse_once", 32'(expired_a), 0);
      run(12, "t6_auto_zero");
      stop = 1'b1; cyc("t6_stop2"); stop = 1'b0;
      load_en = 1'b1; load_val = 5'd5; cyc("t6_load5"); load_en = 1'b0;
      start = 1'b1; cyc("t6_start5"); start = 1'b0;
      cyc("t6_p1_a");
      chk("t6_p1_step1", 32'(step_c), 1);
      cyc("t6_p1_b");
      chk("t6_p1_step2", 32'(count_c), 3);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         reset   = ($urandom_range(0, 199) == 0);
         stop    = ($urandom_range(0, 59) == 0);
         start   = ($urandom_range(0, 29) == 0);
         load_en = ($urandom_range(0, 19) == 0);
         load_val = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
         if ($urandom_range(0, 9) == 0) pause = ~pause;
         cyc("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
